// File: rtl/gaussian_conv_5x5_if.sv
// Column-in / filtered-pixel-out bundle for the 5x5 Gaussian consumer stage.
// enable is a one-way strobe with no backpressure: every clock edge with enable=1 accepts one
// column (row_0..row_4, sof); pixel_out/eol_out/eof_out are meaningful only while valid_out=1.
interface gaussian_conv_5x5_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  enable;
  logic                  sof;
  logic [DATA_WIDTH-1:0] row_0;
  logic [DATA_WIDTH-1:0] row_1;
  logic [DATA_WIDTH-1:0] row_2;
  logic [DATA_WIDTH-1:0] row_3;
  logic [DATA_WIDTH-1:0] row_4;
  logic [DATA_WIDTH-1:0] pixel_out;
  logic                  valid_out;
  logic                  eol_out;
  logic                  eof_out;

  modport master (
    output enable, sof, row_0, row_1, row_2, row_3, row_4,
    input  pixel_out, valid_out, eol_out, eof_out
  );

  modport slave (
    input  enable, sof, row_0, row_1, row_2, row_3, row_4,
    output pixel_out, valid_out, eol_out, eof_out
  );
endinterface

// File: rtl/gaussian_conv_5x5.sv
// Separable 5x5 binomial blur: vertical [1 4 6 4 1] sum per beat, 5-column window,
// horizontal [1 4 6 4 1] sum, rounded /256, with end-of-line / end-of-frame tags.
module gaussian_conv_5x5 #(
  parameter int DATA_WIDTH   = 8,
  parameter int LINE_WIDTH   = 1920,
  parameter int FRAME_HEIGHT = 1080
) (
  input logic                clk,
  input logic                rst,
  gaussian_conv_5x5_if.slave bus
);
  localparam int VW = DATA_WIDTH + 4;
  localparam int HW = DATA_WIDTH + 8;
  localparam int XW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam int YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(LINE_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);
  localparam logic [XW-1:0] X_MIN  = XW'(4);
  localparam logic [YW-1:0] Y_MIN  = YW'(4);
  localparam logic [HW-1:0] HALF   = HW'(1) << (DATA_WIDTH - 1);

  logic [XW-1:0] r_x, w_beat_x, w_x_next;
  logic [YW-1:0] r_y, w_beat_y, w_y_next;
  logic [VW-1:0] w_v;
  logic [VW-1:0] r_w [0:4];
  logic          w_win_ok, w_eol, w_eof;
  logic          r_b_ok, r_b_eol, r_b_eof;
  logic [HW-1:0] w_h, r_h, w_round;
  logic          r_s1_ok, r_s1_eol, r_s1_eof;

  always_comb begin
    w_beat_x = bus.sof ? '0 : r_x;
    w_beat_y = bus.sof ? '0 : r_y;
    w_x_next = (w_beat_x == X_LAST) ? '0 : w_beat_x + XW'(1);
    w_y_next = w_beat_y;
    if (w_beat_x == X_LAST) begin
      w_y_next = (w_beat_y == Y_LAST) ? '0 : w_beat_y + YW'(1);
    end
    // The window still holds the previous line's tail until x reaches 4; win_ok masks it.
    w_win_ok = (w_beat_x >= X_MIN) && (w_beat_y >= Y_MIN);
    w_eol    = w_win_ok && (w_beat_x == X_LAST);
    w_eof    = w_eol && (w_beat_y == Y_LAST);
    w_v = VW'(bus.row_0) + (VW'(bus.row_1) << 2) + (VW'(bus.row_2) << 2) +
          (VW'(bus.row_2) << 1) + (VW'(bus.row_3) << 2) + VW'(bus.row_4);
    w_h = HW'(r_w[0]) + (HW'(r_w[1]) << 2) + (HW'(r_w[2]) << 2) +
          (HW'(r_w[2]) << 1) + (HW'(r_w[3]) << 2) + HW'(r_w[4]);
    w_round = r_h + HALF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x           <= '0;
      r_y           <= '0;
      for (int i = 0; i < 5; i++) r_w[i] <= '0;
      r_b_ok        <= 1'b0;
      r_b_eol       <= 1'b0;
      r_b_eof       <= 1'b0;
      r_h           <= '0;
      r_s1_ok       <= 1'b0;
      r_s1_eol      <= 1'b0;
      r_s1_eof      <= 1'b0;
      bus.pixel_out <= '0;
      bus.valid_out <= 1'b0;
      bus.eol_out   <= 1'b0;
      bus.eof_out   <= 1'b0;
    end else begin
      if (bus.enable) begin
        r_x    <= w_x_next;
        r_y    <= w_y_next;
        r_w[0] <= r_w[1];
        r_w[1] <= r_w[2];
        r_w[2] <= r_w[3];
        r_w[3] <= r_w[4];
        r_w[4] <= w_v;
      end
      // Tags are single-cycle so an enable gap never replays a result.
      r_b_ok        <= bus.enable && w_win_ok;
      r_b_eol       <= bus.enable && w_eol;
      r_b_eof       <= bus.enable && w_eof;
      r_h           <= w_h;
      r_s1_ok       <= r_b_ok;
      r_s1_eol      <= r_b_eol;
      r_s1_eof      <= r_b_eof;
      bus.valid_out <= r_s1_ok;
      bus.eol_out   <= r_s1_eol;
      bus.eof_out   <= r_s1_eof;
      if (r_s1_ok) bus.pixel_out <= w_round[HW-1:DATA_WIDTH];
    end
  end
endmodule

// File: tb/tb_gaussian_conv_5x5.sv
// Bench for gaussian_conv_5x5: random and directed frames against a direct 5x5 convolution model.
module tb_gaussian_conv_5x5;
  localparam int DW = 8;
  localparam int LW = 8;
  localparam int FH = 6;
  localparam int FRAME_OUT = (LW - 4) * (FH - 4);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gaussian_conv_5x5_if #(.DATA_WIDTH(DW)) bus ();
  gaussian_conv_5x5 #(.DATA_WIDTH(DW), .LINE_WIDTH(LW), .FRAME_HEIGHT(FH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int n_valid, n_eol, n_eof, max_pix;

  // scoreboard entry: {expected cycle[31:0], eol, eof, pixel[7:0]}
  logic [41:0] exp_q[$];

  // reference model state: coordinates and the last five accepted columns
  int mx = 0;
  int my = 0;
  logic [4:0][7:0] hist [5];
  int kern [5] = '{1, 4, 6, 4, 1};

  task automatic model_beat(input logic s, input logic [4:0][7:0] rv, input int acc_cyc);
    int bx, by, sum;
    bx = s ? 0 : mx;
    by = s ? 0 : my;
    for (int c = 0; c < 4; c++) hist[c] = hist[c + 1];
    hist[4] = rv;
    if (bx >= 4 && by >= 4) begin
      sum = 0;
      for (int c = 0; c < 5; c++)
        for (int r = 0; r < 5; r++)
          sum += kern[c] * kern[r] * int'(hist[c][r]);
      exp_q.push_back({32'(acc_cyc + 2), (bx == LW - 1), (bx == LW - 1 && by == FH - 1),
                       8'((sum + 128) / 256)});
    end
    mx = bx + 1;
    my = by;
    if (mx == LW) begin
      mx = 0;
      my = (by + 1 == FH) ? 0 : by + 1;
    end
  endtask

  // driver
  task automatic drive(input logic en, input logic s, input logic [4:0][7:0] rv);
    @(negedge clk);
    bus.enable = en;
    bus.sof    = s;
    bus.row_0  = rv[0];
    bus.row_1  = rv[1];
    bus.row_2  = rv[2];
    bus.row_3  = rv[3];
    bus.row_4  = rv[4];
    if (en) model_beat(s, rv, cyc + 1);
  endtask

  function automatic logic [4:0][7:0] make_col(input int mode, input int idx, input int imp);
    logic [4:0][7:0] rv;
    for (int r = 0; r < 5; r++) begin
      case (mode)
        0:       rv[r] = 8'd100;
        1:       rv[r] = 8'd255;
        3:       rv[r] = (idx == imp && r == 2) ? 8'd255 : 8'd0;
        default: rv[r] = 8'($urandom_range(0, 255));
      endcase
    end
    return rv;
  endfunction

  // gap_mode: 0 none, 1 enable pattern 1,0,0,1, 2 random; sof on beat 0 and on sof2
  task automatic send_beats(input int n, input int mode, input int gap_mode, input int sof2,
                            input int imp);
    int acc, t;
    logic en;
    acc = 0;
    t = 0;
    while (acc < n) begin
      case (gap_mode)
        0:       en = 1'b1;
        1:       en = (t % 4 == 0) || (t % 4 == 3);
        default: en = 1'($urandom_range(0, 1));
      endcase
      if (en) begin
        drive(1'b1, (acc == 0) || (acc == sof2), make_col(mode, acc, imp));
        acc++;
      end else begin
        drive(1'b0, 1'($urandom_range(0, 1)), make_col(2, 0, 0));
      end
      t++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, make_col(2, 0, 0));
  endtask

  task automatic clear_counts();
    n_valid = 0;
    n_eol   = 0;
    n_eof   = 0;
    max_pix = 0;
  endtask

  // scoreboard: every valid pulse must match the head entry in value, tags and cycle
  always @(negedge clk) begin
    logic [41:0] e;
    if (bus.valid_out === 1'b1) begin
      n_valid++;
      if (bus.eol_out) n_eol++;
      if (bus.eof_out) n_eof++;
      if (int'(bus.pixel_out) > max_pix) max_pix = int'(bus.pixel_out);
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_valid cyc=%0d pixel=%0d required=no pulse", cyc, bus.pixel_out);
      end else begin
        e = exp_q.pop_front();
        if ({32'(cyc), bus.eol_out, bus.eof_out, bus.pixel_out} !== e)
          $display("FAIL output cyc=%0d eol=%b eof=%b pixel=%0d required cyc=%0d eol=%b eof=%b pixel=%0d",
                   cyc, bus.eol_out, bus.eof_out, bus.pixel_out,
                   int'(e[41:10]), e[9], e[8], e[7:0]);
        else pass_cnt++;
      end
    end else if (exp_q.size() > 0 && int'(exp_q[0][41:10]) < cyc) begin
      chk_cnt++;
      e = exp_q.pop_front();
      $display("FAIL missing_valid at cyc=%0d required pixel=%0d", int'(e[41:10]), e[7:0]);
    end
  end

  task automatic check_frame(input string name, input int nv, input int ne, input int nf);
    idle(5);
    chk_cnt++;
    if (n_valid !== nv) $display("FAIL %s_count got=%0d required=%0d", name, n_valid, nv);
    else pass_cnt++;
    chk_cnt++;
    if (n_eol !== ne) $display("FAIL %s_eol got=%0d required=%0d", name, n_eol, ne);
    else pass_cnt++;
    chk_cnt++;
    if (n_eof !== nf) $display("FAIL %s_eof got=%0d required=%0d", name, n_eof, nf);
    else pass_cnt++;
    chk_cnt++;
    if (exp_q.size() !== 0) $display("FAIL %s_drain pending=%0d required=0", name, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (bus.valid_out !== 1'b0) $display("FAIL reset_valid got=%b required=0", bus.valid_out);
    else pass_cnt++;
    chk_cnt++;
    if (bus.pixel_out !== 8'd0) $display("FAIL reset_pixel got=%0d required=0", bus.pixel_out);
    else pass_cnt++;
    chk_cnt++;
    if (bus.eol_out !== 1'b0) $display("FAIL reset_eol got=%b required=0", bus.eol_out);
    else pass_cnt++;
    chk_cnt++;
    if (bus.eof_out !== 1'b0) $display("FAIL reset_eof got=%b required=0", bus.eof_out);
    else pass_cnt++;
    rst = 1'b0;
    mx = 0;
    my = 0;
  endtask

  task automatic test_constant();
    clear_counts();
    send_beats(LW * FH, 0, 0, -1, -1);
    check_frame("constant", FRAME_OUT, FH - 4, 1);
    chk_cnt++;
    if (max_pix !== 100) $display("FAIL constant_value got=%0d required=100", max_pix);
    else pass_cnt++;
  endtask

  task automatic test_impulse();
    int k;
    k = $urandom_range(4, LW - 3);
    clear_counts();
    send_beats(LW * FH, 3, 0, -1, 4 * LW + k);
    check_frame("impulse", FRAME_OUT, FH - 4, 1);
    chk_cnt++;
    if (max_pix !== 36) $display("FAIL impulse_peak got=%0d required=36", max_pix);
    else pass_cnt++;
    clear_counts();
    send_beats(LW * FH, 1, 0, -1, -1);
    check_frame("full_range", FRAME_OUT, FH - 4, 1);
    chk_cnt++;
    if (max_pix !== 255) $display("FAIL full_range_value got=%0d required=255", max_pix);
    else pass_cnt++;
  endtask

  task automatic test_enable_gaps();
    clear_counts();
    send_beats(LW * FH, 0, 1, -1, -1);
    check_frame("gaps", FRAME_OUT, FH - 4, 1);
  endtask

  task automatic test_sof_resync();
    clear_counts();
    send_beats(20 + LW * FH, 2, 0, 20, -1);
    check_frame("resync", FRAME_OUT, FH - 4, 1);
  endtask

  task automatic test_reset_mid();
    clear_counts();
    send_beats(4 * LW + 5, 2, 0, -1, -1);
    @(negedge clk);
    rst = 1'b1;
    bus.enable = 1'b0;
    exp_q.delete();
    mx = 0;
    my = 0;
    @(negedge clk);
    rst = 1'b0;
    chk_cnt++;
    if (bus.valid_out !== 1'b0) $display("FAIL midreset_valid got=%b required=0", bus.valid_out);
    else pass_cnt++;
    chk_cnt++;
    if (bus.pixel_out !== 8'd0) $display("FAIL midreset_pixel got=%0d required=0", bus.pixel_out);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (bus.valid_out !== 1'b0) $display("FAIL midreset_lost got=%b required=0", bus.valid_out);
    else pass_cnt++;
    clear_counts();
    send_beats(LW * FH, 2, 0, -1, -1);
    check_frame("after_reset", FRAME_OUT, FH - 4, 1);
  endtask

  task automatic test_back_to_back();
    clear_counts();
    send_beats(2 * LW * FH, 2, 2, -1, -1);
    check_frame("random", 2 * FRAME_OUT, 2 * (FH - 4), 2);
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.sof    = 1'b0;
    bus.row_0  = '0;
    bus.row_1  = '0;
    bus.row_2  = '0;
    bus.row_3  = '0;
    bus.row_4  = '0;
    test_reset();
    test_constant();
    test_impulse();
    test_enable_gaps();
    test_sof_resync();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout cyc=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/gaussian_conv_5x5.md
Name: gaussian_conv_5x5

Overview:
- Consumer end of the 5-row aligned line-buffer stage in the Gaussian path.
- Takes one column of five vertically aligned pixels per accepted beat, holding lines y-4..y at column x.
- Keeps a 5-column window, applies the separable 5x5 binomial kernel [1 4 6 4 1]x[1 4 6 4 1]/256 with rounding, and emits one filtered pixel per interior window position with end-of-line and end-of-frame markers.

Parameters:
DATA_WIDTH, 8, bits per pixel.
LINE_WIDTH, 1920, pixels per line; must be at least 5.
FRAME_HEIGHT, 1080, lines per frame; must be at least 5.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
enable  input  1  beat strobe; row inputs and sof are sampled only when high.
sof  input  1  start of frame; qualified by enable; marks the beat as coordinate (0,0).
row_0  input  DATA_WIDTH  oldest line (y-4), column x.
row_1  input  DATA_WIDTH  line y-3.
row_2  input  DATA_WIDTH  line y-2 (kernel centre line).
row_3  input  DATA_WIDTH  line y-1.
row_4  input  DATA_WIDTH  newest line (y).
pixel_out  output  DATA_WIDTH  filtered pixel for centre (x-2, y-2).
valid_out  output  1  one-cycle pulse per filtered pixel.
eol_out  output  1  with valid_out; last output pixel of an output line.
eof_out  output  1  with valid_out; last output pixel of the frame.

Behaviour:
- Reset (rst=1 at a clock edge): x=0, y=0; vertical-sum window, pipeline data and valid tags cleared; pixel_out=0, valid_out=0, eol_out=0, eof_out=0. In-flight results are discarded. Reset dominates enable.
- Coordinates: on an accepted beat, the beat coordinate is (0,0) if sof=1, otherwise the current (x,y).
- Coordinate update after each beat:
  - x_next = beat_x+1, wrapping to 0 at LINE_WIDTH.
  - On the x wrap, y_next = beat_y+1, wrapping to 0 at FRAME_HEIGHT.
  - A beat with sof=1 therefore leaves the counters at (1,0).
- Vertical sum (combinational): v = r0 + 4*r1 + 6*r2 + 4*r3 + r4, width DATA_WIDTH+4, unsigned, no truncation.
- Window: 5-entry shift register w0..w4, where w4 is the newest. On an accepted beat, v shifts into w4 and the oldest entry is dropped. With enable=0 the window, counters and sof are frozen.
- Window-valid tag: win_ok = (beat_x >= 4) && (beat_y >= 4), evaluated per accepted beat.
  - The stale previous-line tail in the window at line start is never used because win_ok gates it.
- Stage 1 (the edge after the accepting edge):
  - h = w0 + 4*w1 + 6*w2 + 4*w3 + w4, width DATA_WIDTH+8, registered.
  - win_ok, eol tag (beat_x == LINE_WIDTH-1) and eof tag (eol && beat_y == FRAME_HEIGHT-1) are registered alongside.
  - Stage 1 advances every clock regardless of enable.
- Stage 2 (next edge):
  - pixel_out = (h + 2^(DATA_WIDTH-1)) >> DATA_WIDTH, i.e. (h+128)>>8 for 8-bit data.
  - The maximum result is exactly 2^DATA_WIDTH - 1, so no saturation is needed.
  - valid_out, eol_out and eof_out are registered from the stage-1 tags.
  - pixel_out holds its last value when valid_out=0.
- Latency: valid_out rises exactly 2 clocks after the edge that accepts the window-completing beat, independent of later enable gaps.
  - Back-to-back beats give back-to-back valid pulses.
- Output count per frame: (LINE_WIDTH-4)*(FRAME_HEIGHT-4); no border pixels are produced.
- sof mid-frame: the frame is resynchronised immediately; no output for the new frame until its beat (4,4). Outputs already in flight still complete.
- enable with sof while the counters are already at (0,0): no effect beyond the normal beat.

Test Plan:
- LINE_WIDTH=8, FRAME_HEIGHT=6, all rows constant 100, 48 beats starting with sof -> exactly 8 valid_out pulses, every pixel_out=100; eol_out on pulses 4 and 8; eof_out on pulse 8 only.
- Impulse: all inputs 0 except row_2=255 at a single beat x=k (4 <= k <= LINE_WIDTH-3) -> output centred at x=k gives pixel_out 36 ((255*36+128)>>8); its horizontal neighbours give 24 ((255*24+128)>>8); full range check with all inputs 255 gives 255.
- Enable gaps: repeat the constant-100 test with enable toggling 1,0,0,1 -> identical pixel values and count; each valid_out exactly 2 clocks after its completing beat.
- sof resync: assert sof at beat 20 of a small frame -> counters restart at (1,0), no output until the new frame's (4,4), then 8 valid pulses.
- Reset mid-frame: rst=1 for one cycle one clock after a completing beat -> that result is lost, valid_out=0 and pixel_out=0 the cycle after reset, and the next frame filters correctly.
